arkhe_levitator_drive: RTL and testbench
========================================

ARKHE_LEVITATOR_DRIVE -- requirements
Module: arkhe_levitator_drive

Interface
REQ-001 Parameter FTW_DEFAULT, 32'h001A36E3, reset tuning word (40 kHz carrier at 100 MHz).
REQ-002 Parameter RAMP_DIV, 1000, clock cycles per amplitude ramp tick (minimum 1).
REQ-003 Parameter RAMP_STEP, 16'd64, amplitude change per ramp tick.
REQ-004 Parameter SLEW_MAX, 16'd256, maximum phase-offset change per carrier period.
REQ-005 Parameter ADC_DECIM, 16, carrier periods between adc_start pulses (minimum 1).
REQ-006 Port clk_100mhz  in  1  system clock; all logic on rising edge.
REQ-007 Port rst  in  1  synchronous, active-high reset.
REQ-008 Port trap_active  in  1  request levitation field on (level).
REQ-009 Port phase_adjust  in  16  target B-channel phase offset, unsigned, 2^16 = 360 deg.
REQ-010 Port fault_in  in  1  transducer overtemp/overcurrent (level).
REQ-011 Port ftw_load / ftw_in  in  1 / 32  tuning-word load strobe and value.
REQ-012 Port drive_a, drive_b  out  1 each  transducer PWM drives.
REQ-013 Port amplitude  out  16  current drive amplitude (0..16'hFFFF).
REQ-014 Port trap_ready  out  1  high only in HOLD.
REQ-015 Port adc_start  out  1  one-cycle ADC sample trigger.
REQ-016 Port drv_state  out  3  FSM state: OFF=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3, FAULT=4.

Function
REQ-017 32-bit accumulator acc += ftw every cycle; a carrier wrap is the cycle acc carries out of bit 31.
REQ-018 Phase A = acc[31:16]; phase B = acc[31:16] + 16'h8000 + phase_off (mod 2^16), anti-phase at phase_off=0.
REQ-019 drive_x registered, high when phase_x < {1'b0, amplitude[15:1]}; one cycle latency from acc; both low when amplitude=0.
REQ-020 On each wrap, phase_off moves toward phase_adjust by the signed 16-bit difference (shortest path; diff=16'h8000 treated as +), clamped to ±SLEW_MAX; exact when |diff| <= SLEW_MAX.
REQ-021 ftw_load accepted only in OFF; ftw_in=0 ignored; load effective next cycle; ftw_load in any other state ignored.
REQ-022 OFF: amplitude=0; trap_active=1 and fault_in=0 -> RAMP_UP.
REQ-023 RAMP_UP: every RAMP_DIV cycles amplitude += RAMP_STEP, saturating at 16'hFFFF; on reaching 16'hFFFF -> HOLD; trap_active=0 -> RAMP_DOWN keeping current amplitude.
REQ-024 HOLD: trap_ready=1; trap_active=0 -> RAMP_DOWN.
REQ-025 RAMP_DOWN: every RAMP_DIV cycles amplitude -= RAMP_STEP, saturating at 0; at 0 -> OFF; trap_active=1 -> RAMP_UP from current amplitude.
REQ-026 Tick counter restarts at 0 on every state change.
REQ-027 fault_in=1 in any state -> FAULT next cycle; amplitude forced 0 and drives low on that same edge; fault overrides all other inputs.
REQ-028 FAULT exits to OFF only when fault_in=0 and trap_active=0 in the same cycle.
REQ-029 adc_start pulses for one cycle on every ADC_DECIM-th wrap while in HOLD; decimation counter clears on leaving HOLD.

Reset
REQ-030 rst: state OFF, acc=0, ftw=FTW_DEFAULT, phase_off=0, amplitude=0, tick/decim counters 0.
REQ-031 rst: drive_a=drive_b=0, trap_ready=0, adc_start=0, drv_state=0; rst mid-ramp discards amplitude immediately.

Configuration
REQ-032 Macro ARKHE_DRIVE_DITHER_EN defined: 16-bit Fibonacci LFSR (taps 16,14,13,11, reset 16'hACE1) steps every cycle; lfsr[3:0] added to both phase A and phase B before the PWM compare.
REQ-033 ARKHE_DRIVE_DITHER_EN undefined: no LFSR logic; phases exactly per REQ-018.

Verification
REQ-034 RAMP_DIV=4, RAMP_STEP=16'h4000, trap_active=1 -> amplitude 4000,8000,C000,FFFF at 4-cycle ticks, HOLD, trap_ready=1.
REQ-035 In HOLD set trap_active=0 -> amplitude BFFF,7FFF,3FFF,0 per tick, then OFF, drives low.
REQ-036 phase_adjust=16'h0400, SLEW_MAX=256 -> phase_off 0100,0200,0300,0400 over 4 wraps, then constant.
REQ-037 fault_in=1 during HOLD -> next cycle FAULT, amplitude=0; release fault with trap_active=1 -> stays FAULT until trap_active=0.
REQ-038 ftw_load in HOLD ignored; ftw_load with 32'h0 in OFF ignored; ADC_DECIM=2 in HOLD -> adc_start on every 2nd wrap.
REQ-039 rst asserted mid RAMP_UP (amplitude 8000) -> next cycle OFF, amplitude 0, all outputs 0.

Source files
------------

// File: rtl/arkhe_levitator_drive.sv
// arkhe_levitator_drive: two-channel transducer PWM driver for an acoustic levitator.
// A 32-bit phase accumulator sets the carrier. Channel B runs anti-phase to channel A
// plus a slew-limited phase offset. An FSM ramps the drive amplitude up and down, and
// the ADC trigger is decimated from carrier wraps while the field is held.
//
// Ports:
//   clk_100mhz    system clock, rising edge
//   rst           synchronous active-high reset
//   trap_active   request field on (level)
//   phase_adjust  target B-channel phase offset, 2^16 = 360 deg
//   fault_in      transducer overtemp/overcurrent (level)
//   ftw_load      tuning-word load strobe, honoured only in OFF
//   ftw_in        tuning word to load
//   drive_a       registered PWM drive, channel A
//   drive_b       registered PWM drive, channel B
//   amplitude     current drive amplitude
//   trap_ready    high only in HOLD
//   adc_start     one-cycle ADC sample trigger
//   drv_state     OFF=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3, FAULT=4
//
// Optional feature: define ARKHE_DRIVE_DITHER_EN to add 4-bit LFSR dither to both PWM phases.
module arkhe_levitator_drive #(
   parameter logic [31:0] FTW_DEFAULT = 32'h001A36E3,
   parameter int unsigned RAMP_DIV    = 1000,
   parameter logic [15:0] RAMP_STEP   = 16'd64,
   parameter logic [15:0] SLEW_MAX    = 16'd256,
   parameter int unsigned ADC_DECIM   = 16
) (
   input  logic        clk_100mhz,
   input  logic        rst,
   input  logic        trap_active,
   input  logic [15:0] phase_adjust,
   input  logic        fault_in,
   input  logic        ftw_load,
   input  logic [31:0] ftw_in,
   output logic        drive_a,
   output logic        drive_b,
   output logic [15:0] amplitude,
   output logic        trap_ready,
   output logic        adc_start,
   output logic [2:0]  drv_state
);

   localparam int unsigned TICK_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam int unsigned DECIM_W = (ADC_DECIM > 1) ? $clog2(ADC_DECIM) : 1;
   localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(RAMP_DIV - 1);
   localparam logic [DECIM_W-1:0] DECIM_LAST = DECIM_W'(ADC_DECIM - 1);

   typedef enum logic [2:0] {
      StOff      = 3'd0,
      StRampUp   = 3'd1,
      StHold     = 3'd2,
      StRampDown = 3'd3,
      StFault    = 3'd4
   } drv_state_e;

   drv_state_e         state_q, state_d;
   logic [31:0]        acc_q, acc_d;
   logic [31:0]        ftw_q, ftw_d;
   logic [15:0]        phase_off_q, phase_off_d;
   logic [15:0]        amplitude_q, amplitude_d;
   logic [TICK_W-1:0]  tick_q, tick_d;
   logic [DECIM_W-1:0] decim_q, decim_d;
   logic               drive_a_q, drive_a_d;
   logic               drive_b_q, drive_b_d;
   logic               trap_ready_q, trap_ready_d;
   logic               adc_start_q, adc_start_d;

   logic [32:0] acc_sum;
   logic        wrap;
   logic [16:0] amp_sum;
   logic [15:0] amp_up, amp_down;
   logic [15:0] diff, mag, slew;
   logic        diff_neg;
   logic [15:0] dither, phase_a, phase_b, threshold;

`ifdef ARKHE_DRIVE_DITHER_EN
   logic [15:0] lfsr_q, lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      dither = {12'h000, lfsr_q[3:0]};
   end

   always_ff @(posedge clk_100mhz) begin
      if (rst) lfsr_q <= 16'hACE1;
      else     lfsr_q <= lfsr_d;
   end
`else
   always_comb dither = 16'h0000;
`endif

   always_comb begin
      // Carrier accumulator; a wrap is the carry out of bit 31.
      acc_sum = {1'b0, acc_q} + {1'b0, ftw_q};
      wrap    = acc_sum[32];
      acc_d   = acc_sum[31:0];

      ftw_d = ftw_q;
      if (state_q == StOff && ftw_load && ftw_in != 32'h0) ftw_d = ftw_in;

      // Shortest-path slew toward phase_adjust; a half-turn difference counts as positive.
      diff        = phase_adjust - phase_off_q;
      diff_neg    = diff[15] && (diff != 16'h8000);
      mag         = diff_neg ? (16'h0000 - diff) : diff;
      slew        = (mag > SLEW_MAX) ? SLEW_MAX : mag;
      phase_off_d = phase_off_q;
      if (wrap) phase_off_d = diff_neg ? (phase_off_q - slew) : (phase_off_q + slew);

      amp_sum  = {1'b0, amplitude_q} + {1'b0, RAMP_STEP};
      amp_up   = amp_sum[16] ? 16'hFFFF : amp_sum[15:0];
      amp_down = (amplitude_q > RAMP_STEP) ? (amplitude_q - RAMP_STEP) : 16'h0000;

      state_d     = state_q;
      amplitude_d = amplitude_q;
      case (state_q)
         StOff: begin
            amplitude_d = 16'h0000;
            if (trap_active) state_d = StRampUp;
         end
         StRampUp: begin
            if (!trap_active) begin
               state_d = StRampDown;
            end else if (tick_q == TICK_LAST) begin
               amplitude_d = amp_up;
               if (amp_up == 16'hFFFF) state_d = StHold;
            end
         end
         StHold: begin
            if (!trap_active) state_d = StRampDown;
         end
         StRampDown: begin
            if (trap_active) begin
               state_d = StRampUp;
            end else if (tick_q == TICK_LAST) begin
               amplitude_d = amp_down;
               if (amp_down == 16'h0000) state_d = StOff;
            end
         end
         StFault: begin
            amplitude_d = 16'h0000;
            if (!trap_active) state_d = StOff;
         end
         default: begin
            state_d     = StOff;
            amplitude_d = 16'h0000;
         end
      endcase
      if (fault_in) begin
         state_d     = StFault;
         amplitude_d = 16'h0000;
      end

      // Tick counter runs only while ramping and restarts on any state change.
      tick_d = '0;
      if ((state_q == StRampUp || state_q == StRampDown) && tick_q != TICK_LAST)
         tick_d = tick_q + 1'b1;
      if (state_d != state_q) tick_d = '0;

      adc_start_d = 1'b0;
      decim_d     = '0;
      if (state_q == StHold && state_d == StHold) begin
         decim_d = decim_q;
         if (wrap) begin
            if (decim_q == DECIM_LAST) begin
               adc_start_d = 1'b1;
               decim_d     = '0;
            end else begin
               decim_d = decim_q + 1'b1;
            end
         end
      end

      phase_a   = acc_q[31:16] + dither;
      phase_b   = acc_q[31:16] + 16'h8000 + phase_off_q + dither;
      threshold = {1'b0, amplitude_q[15:1]};
      drive_a_d = (phase_a < threshold) && !fault_in;
      drive_b_d = (phase_b < threshold) && !fault_in;

      trap_ready_d = (state_d == StHold);
   end

   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         state_q      <= StOff;
         acc_q        <= 32'h0;
         ftw_q        <= FTW_DEFAULT;
         phase_off_q  <= 16'h0;
         amplitude_q  <= 16'h0;
         tick_q       <= '0;
         decim_q      <= '0;
         drive_a_q    <= 1'b0;
         drive_b_q    <= 1'b0;
         trap_ready_q <= 1'b0;
         adc_start_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         ftw_q        <= ftw_d;
         phase_off_q  <= phase_off_d;
         amplitude_q  <= amplitude_d;
         tick_q       <= tick_d;
         decim_q      <= decim_d;
         drive_a_q    <= drive_a_d;
         drive_b_q    <= drive_b_d;
         trap_ready_q <= trap_ready_d;
         adc_start_q  <= adc_start_d;
      end
   end

   assign drive_a    = drive_a_q;
   assign drive_b    = drive_b_q;
   assign amplitude  = amplitude_q;
   assign trap_ready = trap_ready_q;
   assign adc_start  = adc_start_q;
   assign drv_state  = state_q;

endmodule

// File: tb/tb_arkhe_levitator_drive.sv
// Directed bench for arkhe_levitator_drive. The tuning word is 32'h2000_0000, so the carrier
// wraps every 8 cycles and the accumulator only ever holds multiples of 32'h2000_0000.
module tb_arkhe_levitator_drive;

   logic        clk_100mhz = 1'b0;
   logic        rst;
   logic        trap_active;
   logic [15:0] phase_adjust;
   logic        fault_in;
   logic        ftw_load;
   logic [31:0] ftw_in;
   logic        drive_a, drive_b;
   logic [15:0] amplitude;
   logic        trap_ready, adc_start;
   logic [2:0]  drv_state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_100mhz = ~clk_100mhz;

   arkhe_levitator_drive #(
      .FTW_DEFAULT (32'h2000_0000),
      .RAMP_DIV    (4),
      .RAMP_STEP   (16'h4000),
      .SLEW_MAX    (16'd256),
      .ADC_DECIM   (2)
   ) dut (
      .clk_100mhz   (clk_100mhz),
      .rst          (rst),
      .trap_active  (trap_active),
      .phase_adjust (phase_adjust),
      .fault_in     (fault_in),
      .ftw_load     (ftw_load),
      .ftw_in       (ftw_in),
      .drive_a      (drive_a),
      .drive_b      (drive_b),
      .amplitude    (amplitude),
      .trap_ready   (trap_ready),
      .adc_start    (adc_start),
      .drv_state    (drv_state)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and settle 1 ns past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk_100mhz);
      #1;
   endtask

   initial begin
      int adc_cnt, first_i, last_i, a_hi, b_hi, same;
      rst          = 1'b1;
      trap_active  = 1'b0;
      phase_adjust = 16'h0000;
      fault_in     = 1'b0;
      ftw_load     = 1'b0;
      ftw_in       = 32'h0;
      step(3);
      check_eq("rst_state", drv_state, 3'd0);
      check_eq("rst_amp", amplitude, 16'h0);
      check_eq("rst_drives", {drive_a, drive_b}, 2'b00);
      check_eq("rst_ready", trap_ready, 1'b0);
      check_eq("rst_adc", adc_start, 1'b0);

      // Phase-offset slew: one 256 step per wrap, wraps every 8 cycles.
      rst          = 1'b0;
      phase_adjust = 16'h0400;
      step(8);
      check_eq("slew_1", dut.phase_off_q, 16'h0100);
      step(8);
      check_eq("slew_2", dut.phase_off_q, 16'h0200);
      step(8);
      check_eq("slew_3", dut.phase_off_q, 16'h0300);
      step(8);
      check_eq("slew_4", dut.phase_off_q, 16'h0400);
      step(8);
      check_eq("slew_hold", dut.phase_off_q, 16'h0400);
      check_eq("off_drives", {drive_a, drive_b}, 2'b00);

      // Tuning-word loads in OFF: zero ignored, nonzero taken.
      ftw_load = 1'b1;
      ftw_in   = 32'h0;
      step(1);
      check_eq("ftw_zero", dut.ftw_q, 32'h2000_0000);
      ftw_in = 32'h4000_0000;
      step(1);
      check_eq("ftw_load", dut.ftw_q, 32'h4000_0000);
      ftw_in = 32'h2000_0000;
      step(1);
      ftw_load = 1'b0;
      check_eq("ftw_restore", dut.ftw_q, 32'h2000_0000);

      // Ramp up: 4-cycle ticks of 16'h4000, saturating into HOLD.
      trap_active = 1'b1;
      step(1);
      check_eq("up_enter", drv_state, 3'd1);
      check_eq("up_amp0", amplitude, 16'h0000);
      step(4);
      check_eq("up_4000", amplitude, 16'h4000);
      step(4);
      check_eq("up_8000", amplitude, 16'h8000);
      step(4);
      check_eq("up_c000", amplitude, 16'hC000);
      step(4);
      check_eq("up_ffff", amplitude, 16'hFFFF);
      check_eq("hold_state", drv_state, 3'd2);
      check_eq("hold_ready", trap_ready, 1'b1);

      // 32 cycles of HOLD = 4 wraps -> adc_start on the 2nd and 4th, 16 cycles apart.
      // Threshold 7FFF, offset 0400: A high for phases 0..6000, B exactly complementary.
      adc_cnt = 0; first_i = -1; last_i = -1; a_hi = 0; b_hi = 0; same = 0;
      for (int i = 1; i <= 32; i++) begin
         step(1);
         if (adc_start) begin
            adc_cnt++;
            if (first_i < 0) first_i = i;
            last_i = i;
         end
         if (i >= 9 && i <= 16) begin
            a_hi += int'(drive_a);
            b_hi += int'(drive_b);
            if (drive_a == drive_b) same++;
         end
      end
      check_eq("adc_count", adc_cnt, 2);
      check_eq("adc_spacing", last_i - first_i, 16);
      check_eq("drive_a_duty", a_hi, 4);
      check_eq("drive_b_duty", b_hi, 4);
      check_eq("drive_antiphase", same, 0);

      ftw_load = 1'b1;
      ftw_in   = 32'h1000_0000;
      step(1);
      ftw_load = 1'b0;
      check_eq("ftw_hold_ignored", dut.ftw_q, 32'h2000_0000);

      // Ramp down from HOLD.
      trap_active = 1'b0;
      step(1);
      check_eq("dn_enter", drv_state, 3'd3);
      check_eq("dn_amp_kept", amplitude, 16'hFFFF);
      step(4);
      check_eq("dn_bfff", amplitude, 16'hBFFF);
      step(4);
      check_eq("dn_7fff", amplitude, 16'h7FFF);
      step(4);
      check_eq("dn_3fff", amplitude, 16'h3FFF);
      step(4);
      check_eq("dn_0", amplitude, 16'h0000);
      check_eq("dn_off", drv_state, 3'd0);
      check_eq("dn_ready", trap_ready, 1'b0);
      step(2);
      check_eq("dn_drives", {drive_a, drive_b}, 2'b00);

      // Fault during HOLD, sticky while trap_active stays high.
      trap_active = 1'b1;
      step(17);
      check_eq("hold2_state", drv_state, 3'd2);
      fault_in = 1'b1;
      step(1);
      check_eq("flt_state", drv_state, 3'd4);
      check_eq("flt_amp", amplitude, 16'h0000);
      check_eq("flt_drives", {drive_a, drive_b}, 2'b00);
      check_eq("flt_ready", trap_ready, 1'b0);
      fault_in = 1'b0;
      step(3);
      check_eq("flt_sticky", drv_state, 3'd4);
      trap_active = 1'b0;
      step(1);
      check_eq("flt_exit", drv_state, 3'd0);

      // Reset mid ramp-up at amplitude 8000.
      trap_active = 1'b1;
      step(9);
      check_eq("pre_rst_amp", amplitude, 16'h8000);
      rst = 1'b1;
      step(1);
      check_eq("mid_rst_state", drv_state, 3'd0);
      check_eq("mid_rst_amp", amplitude, 16'h0000);
      check_eq("mid_rst_outs", {drive_a, drive_b, trap_ready, adc_start}, 4'b0000);
      check_eq("mid_rst_phase", dut.phase_off_q, 16'h0000);
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
